// File: rtl/ss_rvc_pkg.sv
// Shared types and constants for the RVC memory responder slice.
package ss_rvc_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned MEM_WORDS_DFLT = 1024;

    typedef logic [XLEN-1:0] t_xlen;
    typedef logic [31:0]     t_instruction;

    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } t_mem_rsp_state;

    localparam t_instruction NOP = 32'h0000_0013;

    // Word-aligned and inside the array.
    function automatic logic is_valid_addr(input t_xlen addr, input int unsigned words);
        return (addr[1:0] == 2'b00) && (32'({2'b00, addr[31:2]}) < words);
    endfunction

endpackage : ss_rvc_pkg

// File: rtl/ss_rvc_mem_array.sv
// Unified word array: one write port, registered fetch and data read ports,
// write-first forwarding on the fetch port.
module ss_rvc_mem_array
    import ss_rvc_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DFLT,
    parameter int unsigned AW        = 10
) (
    input  logic          QClk,
    input  logic          RstQnnnH,
    input  logic          i_we,
    input  logic [AW-1:0] i_w_idx,
    input  t_xlen         i_w_data,
    input  logic          i_f_valid,
    input  logic [AW-1:0] i_f_idx,
    input  logic          i_d_en,
    input  logic          i_d_valid,
    input  logic [AW-1:0] i_d_idx,
    output t_instruction  o_f_data,
    output t_xlen         o_d_data
);

    t_xlen        r_mem [MEM_WORDS];
    t_instruction r_f_data;
    t_xlen        r_d_data;

    // Storage is never reset; a write coinciding with reset is suppressed.
    always_ff @(posedge QClk) begin
        if (i_we && RstQnnnH) begin
            r_mem[i_w_idx] <= i_w_data;
        end
    end

    always_ff @(posedge QClk or negedge RstQnnnH) begin
        if (!RstQnnnH) begin
            r_f_data <= NOP;
            r_d_data <= '0;
        end else begin
            if (!i_f_valid) begin
                r_f_data <= NOP;
            end else if (i_we && (i_w_idx == i_f_idx)) begin
                r_f_data <= i_w_data;
            end else begin
                r_f_data <= r_mem[i_f_idx];
            end

            if (i_d_en) begin
                r_d_data <= i_d_valid ? r_mem[i_d_idx] : '0;
            end
        end
    end

    assign o_f_data = r_f_data;
    assign o_d_data = r_d_data;

endmodule : ss_rvc_mem_array

// File: rtl/ss_rvc_mem_rsp.sv
// Memory responder: boot-time loader FSM, port arbitration and access checks
// in front of the unified instruction/data array.
module ss_rvc_mem_rsp
    import ss_rvc_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DFLT
) (
    input  logic         QClk,
    input  logic         RstQnnnH,
    input  t_xlen        PcQ100H,
    output t_instruction InstructionQ101H,
    input  t_xlen        AddressDmQ103H,
    input  t_xlen        WrDataDmQ103H,
    input  logic         RdEnDmQ103H,
    input  logic         WrEnDmQ103H,
    output t_xlen        RdDataDmQ104H,
    input  logic         LdValid,
    output logic         LdReady,
    input  t_xlen        LdAddr,
    input  t_xlen        LdData,
    input  logic         LdDone,
    input  logic         LdStart,
    output logic         CoreRstQnnnH,
    output logic         MemErrQ104H
);

    localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    t_mem_rsp_state r_state;
    logic           r_core_rst;
    logic           r_ld_ready;
    logic           r_mem_err;

    logic          w_f_ok;
    logic          w_d_ok;
    logic          w_ld_ok;
    logic          w_run;
    logic          w_ld_wr;
    logic          w_core_wr;
    logic          w_core_rd;
    logic          w_we;
    logic [AW-1:0] w_w_idx;
    t_xlen         w_w_data;
    logic          w_err;

    assign w_f_ok  = is_valid_addr(PcQ100H, MEM_WORDS);
    assign w_d_ok  = is_valid_addr(AddressDmQ103H, MEM_WORDS);
    assign w_ld_ok = is_valid_addr(LdAddr, MEM_WORDS);

    // Loader owns the write port in boot, the core owns it in run.
    assign w_run     = (r_state == S_RUN);
    assign w_ld_wr   = LdValid && r_ld_ready;
    assign w_core_wr = WrEnDmQ103H && w_run;
    assign w_core_rd = RdEnDmQ103H && w_run;

    assign w_we     = (w_ld_wr && w_ld_ok) || (w_core_wr && w_d_ok);
    assign w_w_idx  = w_ld_wr ? LdAddr[AW+1:2] : AddressDmQ103H[AW+1:2];
    assign w_w_data = w_ld_wr ? LdData : WrDataDmQ103H;

    assign w_err = !w_f_ok
                || (w_ld_wr && !w_ld_ok)
                || ((w_core_wr || w_core_rd) && !w_d_ok);

    // Boot/run FSM with registered decodes and the sticky error flag.
    always_ff @(posedge QClk or negedge RstQnnnH) begin
        if (!RstQnnnH) begin
            r_state    <= S_BOOT;
            r_core_rst <= 1'b1;
            r_ld_ready <= 1'b1;
            r_mem_err  <= 1'b0;
        end else begin
            if (w_err) begin
                r_mem_err <= 1'b1;
            end
            case (r_state)
                S_BOOT: begin
                    if (LdDone) begin
                        r_state    <= S_RUN;
                        r_core_rst <= 1'b0;
                        r_ld_ready <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (LdStart) begin
                        r_state    <= S_BOOT;
                        r_core_rst <= 1'b1;
                        r_ld_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_BOOT;
                    r_core_rst <= 1'b1;
                    r_ld_ready <= 1'b1;
                end
            endcase
        end
    end

    ss_rvc_mem_array #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_mem_array (
        .QClk      (QClk),
        .RstQnnnH  (RstQnnnH),
        .i_we      (w_we),
        .i_w_idx   (w_w_idx),
        .i_w_data  (w_w_data),
        .i_f_valid (w_f_ok),
        .i_f_idx   (PcQ100H[AW+1:2]),
        .i_d_en    (w_core_rd),
        .i_d_valid (w_d_ok),
        .i_d_idx   (AddressDmQ103H[AW+1:2]),
        .o_f_data  (InstructionQ101H),
        .o_d_data  (RdDataDmQ104H)
    );

    assign LdReady      = r_ld_ready;
    assign CoreRstQnnnH = r_core_rst;
    assign MemErrQ104H  = r_mem_err;

endmodule : ss_rvc_mem_rsp

// File: tb/tb_ss_rvc_mem_rsp.sv
// Directed bench for ss_rvc_mem_rsp: boot load, store/load, forwarding,
// error handling, boot gating, re-load and reset during a load.
module tb_ss_rvc_mem_rsp;
    import ss_rvc_pkg::*;

    logic         QClk;
    logic         RstQnnnH;
    t_xlen        PcQ100H;
    t_instruction InstructionQ101H;
    t_xlen        AddressDmQ103H;
    t_xlen        WrDataDmQ103H;
    logic         RdEnDmQ103H;
    logic         WrEnDmQ103H;
    t_xlen        RdDataDmQ104H;
    logic         LdValid;
    logic         LdReady;
    t_xlen        LdAddr;
    t_xlen        LdData;
    logic         LdDone;
    logic         LdStart;
    logic         CoreRstQnnnH;
    logic         MemErrQ104H;

    int checks   = 0;
    int failures = 0;

    ss_rvc_mem_rsp #(.MEM_WORDS(1024)) dut (
        .QClk             (QClk),
        .RstQnnnH         (RstQnnnH),
        .PcQ100H          (PcQ100H),
        .InstructionQ101H (InstructionQ101H),
        .AddressDmQ103H   (AddressDmQ103H),
        .WrDataDmQ103H    (WrDataDmQ103H),
        .RdEnDmQ103H      (RdEnDmQ103H),
        .WrEnDmQ103H      (WrEnDmQ103H),
        .RdDataDmQ104H    (RdDataDmQ104H),
        .LdValid          (LdValid),
        .LdReady          (LdReady),
        .LdAddr           (LdAddr),
        .LdData           (LdData),
        .LdDone           (LdDone),
        .LdStart          (LdStart),
        .CoreRstQnnnH     (CoreRstQnnnH),
        .MemErrQ104H      (MemErrQ104H)
    );

    initial QClk = 1'b0;
    always #5 QClk = ~QClk;

    task automatic tick();
        @(posedge QClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        RstQnnnH       = 1'b0;
        PcQ100H        = '0;
        AddressDmQ103H = '0;
        WrDataDmQ103H  = '0;
        RdEnDmQ103H    = 1'b0;
        WrEnDmQ103H    = 1'b0;
        LdValid        = 1'b0;
        LdAddr         = '0;
        LdData         = '0;
        LdDone         = 1'b0;
        LdStart        = 1'b0;

        // Reset values
        tick();
        tick();
        chk("rst_instr",   InstructionQ101H, 32'h0000_0013);
        chk("rst_rddata",  RdDataDmQ104H,    32'h0);
        chk("rst_corerst", 32'(CoreRstQnnnH), 32'h1);
        chk("rst_ldready", 32'(LdReady),      32'h1);
        chk("rst_memerr",  32'(MemErrQ104H),  32'h0);
        RstQnnnH = 1'b1;
        tick();

        // Loader writes; the second coincides with LdDone
        LdValid = 1'b1; LdAddr = 32'h0; LdData = 32'h0050_0093;
        tick();
        LdAddr = 32'h4; LdData = 32'h0010_0113; LdDone = 1'b1;
        tick();
        LdValid = 1'b0; LdDone = 1'b0;
        chk("boot_corerst", 32'(CoreRstQnnnH), 32'h0);
        chk("boot_ldready", 32'(LdReady),      32'h0);
        PcQ100H = 32'h0;
        tick();
        chk("fetch_0", InstructionQ101H, 32'h0050_0093);
        PcQ100H = 32'h4;
        tick();
        chk("fetch_4_done_cycle", InstructionQ101H, 32'h0010_0113);

        // Store then load, then hold
        WrEnDmQ103H = 1'b1; AddressDmQ103H = 32'h100; WrDataDmQ103H = 32'hDEAD_BEEF;
        tick();
        WrEnDmQ103H = 1'b0; RdEnDmQ103H = 1'b1;
        tick();
        RdEnDmQ103H = 1'b0;
        chk("load_100", RdDataDmQ104H, 32'hDEAD_BEEF);
        AddressDmQ103H = 32'h4;
        tick();
        chk("load_hold", RdDataDmQ104H, 32'hDEAD_BEEF);

        // Same-cycle fetch and store
        PcQ100H = 32'h8;
        WrEnDmQ103H = 1'b1; AddressDmQ103H = 32'h8; WrDataDmQ103H = 32'h1234_5678;
        tick();
        WrEnDmQ103H = 1'b0;
        chk("fwd_fetch", InstructionQ101H, 32'h1234_5678);
        tick();
        chk("fetch_after_fwd", InstructionQ101H, 32'h1234_5678);
        chk("no_err_yet", 32'(MemErrQ104H), 32'h0);

        // Misaligned read, then out-of-range write
        RdEnDmQ103H = 1'b1; AddressDmQ103H = 32'h102;
        tick();
        RdEnDmQ103H = 1'b0;
        chk("bad_read_data", RdDataDmQ104H, 32'h0);
        chk("bad_read_err",  32'(MemErrQ104H), 32'h1);
        WrEnDmQ103H = 1'b1; AddressDmQ103H = 32'h1000; WrDataDmQ103H = 32'hCAFE_F00D;
        tick();
        WrEnDmQ103H = 1'b0; RdEnDmQ103H = 1'b1; AddressDmQ103H = 32'h0;
        tick();
        RdEnDmQ103H = 1'b0;
        chk("bad_write_dropped", RdDataDmQ104H, 32'h0050_0093);
        chk("err_sticky", 32'(MemErrQ104H), 32'h1);

        // Re-load request; memory retained and D-port gated in boot
        LdStart = 1'b1;
        tick();
        LdStart = 1'b0;
        chk("reload_corerst", 32'(CoreRstQnnnH), 32'h1);
        chk("reload_ldready", 32'(LdReady),      32'h1);
        PcQ100H = 32'h100;
        WrEnDmQ103H = 1'b1; AddressDmQ103H = 32'h100; WrDataDmQ103H = 32'h1111_1111;
        tick();
        WrEnDmQ103H = 1'b0;
        chk("boot_write_gated", InstructionQ101H, 32'hDEAD_BEEF);
        RdEnDmQ103H = 1'b1; AddressDmQ103H = 32'h8;
        tick();
        RdEnDmQ103H = 1'b0;
        chk("boot_read_gated", RdDataDmQ104H, 32'h0050_0093);
        LdDone = 1'b1;
        tick();
        LdDone = 1'b0;
        chk("rerun_corerst", 32'(CoreRstQnnnH), 32'h0);
        RdEnDmQ103H = 1'b1; AddressDmQ103H = 32'h100;
        tick();
        RdEnDmQ103H = 1'b0;
        chk("retained_100", RdDataDmQ104H, 32'hDEAD_BEEF);
        LdDone = 1'b1;
        tick();
        LdDone = 1'b0;
        chk("lddone_in_run_ignored", 32'(CoreRstQnnnH), 32'h0);

        // Reset asserted while a loader write is pending
        LdStart = 1'b1;
        tick();
        LdStart = 1'b0;
        LdValid = 1'b1; LdAddr = 32'h100; LdData = 32'h5555_5555;
        #1;
        RstQnnnH = 1'b0;
        #1;
        chk("midrst_instr",   InstructionQ101H, 32'h0000_0013);
        chk("midrst_rddata",  RdDataDmQ104H,    32'h0);
        chk("midrst_corerst", 32'(CoreRstQnnnH), 32'h1);
        chk("midrst_ldready", 32'(LdReady),      32'h1);
        chk("midrst_memerr",  32'(MemErrQ104H),  32'h0);
        tick();
        LdValid = 1'b0;
        RstQnnnH = 1'b1;
        tick();
        chk("midrst_no_write", InstructionQ101H, 32'hDEAD_BEEF);

        // Invalid fetch addresses
        PcQ100H = 32'h2;
        tick();
        chk("bad_pc_nop", InstructionQ101H, 32'h0000_0013);
        chk("bad_pc_err", 32'(MemErrQ104H),  32'h1);
        PcQ100H = 32'h1000;
        tick();
        chk("oor_pc_nop", InstructionQ101H, 32'h0000_0013);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ss_rvc_mem_rsp

// File: doc/ss_rvc_mem_rsp.md
SS_RVC_MEM_RSP -- requirements
Module: ss_rvc_mem_rsp

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset. Clock and reset ports SHALL be named as in the codebase.
REQ-002 Parameter MEM_WORDS, default 1024, SHALL set the number of 32-bit words in the unified memory.
REQ-003 QClk  in  1  single clock; all state SHALL be updated on its rising edge.
REQ-004 RstQnnnH  in  1  asynchronous reset, active-low.
REQ-005 PcQ100H  in  32  core instruction fetch byte address.
REQ-006 InstructionQ101H  out  32  fetched instruction word.
REQ-007 AddressDmQ103H  in  32  core data byte address.
REQ-008 WrDataDmQ103H  in  32  core store data.
REQ-009 RdEnDmQ103H / WrEnDmQ103H  in  1 each  core load / store strobes; the core never asserts both together.
REQ-010 RdDataDmQ104H  out  32  load data.
REQ-011 LdValid  in  1; LdReady  out  1  loader write handshake.
REQ-012 LdAddr  in  32; LdData  in  32  loader word byte address and data.
REQ-013 LdDone  in  1  end-of-load pulse; LdStart  in  1  re-load request.
REQ-014 CoreRstQnnnH  out  1  active-high reset to the core.
REQ-015 MemErrQ104H  out  1  sticky access-error flag.

Function
REQ-016 FSM states SHALL be S_BOOT and S_RUN.
REQ-017 Reset SHALL enter S_BOOT.
REQ-018 S_BOOT -> S_RUN SHALL occur on LdDone=1.
REQ-019 S_RUN -> S_BOOT SHALL occur on LdStart=1.
REQ-020 LdDone in S_RUN and LdStart in S_BOOT SHALL be ignored.
REQ-021 CoreRstQnnnH SHALL be 1 in S_BOOT and 0 in S_RUN; it is a registered FSM decode.
REQ-022 LdReady SHALL be 1 only in S_BOOT.
REQ-023 A loader write SHALL occur on a cycle with LdValid&&LdReady.
REQ-024 If LdValid&&LdReady and LdDone arrive in the same cycle, the write SHALL complete and the FSM SHALL then move to S_RUN.
REQ-025 Word index SHALL be address[31:2].
REQ-026 An access SHALL be valid when address[1:0]==0 and the index is < MEM_WORDS.
REQ-027 Instruction fetch:
- InstructionQ101H SHALL be a registered read of mem[PcQ100H index].
- Latency SHALL be 1 cycle, every cycle, in both states.
- An invalid PC SHALL return 32'h0000_0013 (NOP) and SHALL set the error flag.
REQ-028 Data read: when RdEnDmQ103H=1 in S_RUN, RdDataDmQ104H SHALL take mem[index] on the next edge (1-cycle latency). Otherwise RdDataDmQ104H SHALL hold its value.
REQ-029 Data write: when WrEnDmQ103H=1 in S_RUN, mem[index] SHALL be updated on the edge.
REQ-030 D-port strobes SHALL be ignored in S_BOOT.
REQ-031 An invalid data read SHALL return 0. An invalid data write or invalid loader write SHALL be dropped. Each SHALL set the error flag.
REQ-032 A fetch from the word being written in the same cycle (core or loader) SHALL return the new data (write-first forwarding).
REQ-033 MemErrQ104H SHALL set one cycle after any invalid access and SHALL clear only on reset.
REQ-034 Memory contents SHALL survive S_RUN -> S_BOOT (LdStart).

Reset
REQ-035 Reset values SHALL be:
- InstructionQ101H = 32'h0000_0013
- RdDataDmQ104H = 0
- CoreRstQnnnH = 1
- LdReady = 1
- MemErrQ104H = 0
- FSM = S_BOOT
REQ-036 Memory contents SHALL NOT be reset.
REQ-037 Reset asserted mid-operation SHALL abort any in-flight write; the array SHALL see no write on that edge.
REQ-038 The first core-visible cycle SHALL follow the LdDone edge.

Structure
REQ-039 t_mem_rsp_state, the NOP constant and MEM_WORDS default SHALL live in ss_rvc_pkg.
REQ-040 Port types SHALL use t_xlen and t_instruction.
REQ-041 Sub-module ss_rvc_mem_array SHALL provide:
- one write port;
- two read ports (fetch, data);
- registered outputs;
- write-first forwarding on the fetch port.
REQ-042 Port arbitration, validity checks and the FSM SHALL reside in ss_rvc_mem_rsp.

Verification
REQ-043 Loader write then boot:
- Stimulus: load 0x0->0x00500093 and 0x4->0x00100113, then LdDone.
- Response: CoreRstQnnnH falls the next cycle; PcQ100H=0 gives InstructionQ101H=0x00500093 one cycle later.
REQ-044 Store then load:
- Stimulus: write 0xDEADBEEF to 0x100, then read 0x100 the following cycle.
- Response: RdDataDmQ104H=0xDEADBEEF exactly one cycle after the read.
REQ-045 Same-cycle fetch/store:
- Stimulus: PcQ100H=0x8 with a store of 0x12345678 to 0x8.
- Response: InstructionQ101H=0x12345678.
REQ-046 Errors:
- Stimulus: read at 0x102, then a write to MEM_WORDS*4.
- Response: RdDataDmQ104H=0; the write is dropped (later read of index 0 unchanged); MemErrQ104H=1 and stays 1 until reset.
REQ-047 Boot gating and re-load:
- Stimulus A: D write in S_BOOT.
- Response A: memory unchanged.
- Stimulus B: LdStart in S_RUN.
- Response B: CoreRstQnnnH=1 and LdReady=1 next cycle; earlier data retained.
REQ-048 Reset mid-load:
- Stimulus: assert RstQnnnH=0 during LdValid.
- Response: all outputs take their reset values immediately; no write occurs.
